// File: rtl/axi4_lite_cmd_master.sv
// AXI4-Lite configuration package, channel bundle and a single-outstanding
// command-to-AXI4-Lite initiator with an optional response timeout.

package axi4_lite_pkg;
  typedef struct packed {
    int unsigned A;  // address width
    int unsigned N;  // data bytes
    int unsigned I;  // ID width, 0 = no ID
  } axi4_lite_cfg_t;
endpackage

interface axi4_lite_if #(
  parameter axi4_lite_pkg::axi4_lite_cfg_t CONFIG = '{A: 32, N: 4, I: 0}
);
  // ID fields keep one bit when I == 0 so the bundle never has zero-width nets.
  localparam int unsigned IW = (CONFIG.I > 0) ? CONFIG.I : 1;

  logic                    awvalid;
  logic                    awready;
  logic [CONFIG.A-1:0]     awaddr;
  logic [2:0]              awprot;
  logic [IW-1:0]           awid;
  logic                    wvalid;
  logic                    wready;
  logic [8*CONFIG.N-1:0]   wdata;
  logic [CONFIG.N-1:0]     wstrb;
  logic                    bvalid;
  logic                    bready;
  logic [1:0]              bresp;
  logic [IW-1:0]           bid;
  logic                    arvalid;
  logic                    arready;
  logic [CONFIG.A-1:0]     araddr;
  logic [2:0]              arprot;
  logic [IW-1:0]           arid;
  logic                    rvalid;
  logic                    rready;
  logic [8*CONFIG.N-1:0]   rdata;
  logic [1:0]              rresp;
  logic [IW-1:0]           rid;

  modport master (
    output awvalid, awaddr, awprot, awid, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, arid, rready,
    input  awready, wready, bvalid, bresp, bid, arready, rvalid, rdata, rresp, rid
  );

  modport slave (
    input  awvalid, awaddr, awprot, awid, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, arid, rready,
    output awready, wready, bvalid, bresp, bid, arready, rvalid, rdata, rresp, rid
  );
endinterface

module axi4_lite_cmd_master
  import axi4_lite_pkg::*;
#(
  parameter axi4_lite_cfg_t CONFIG  = '{A: 32, N: 4, I: 0},
  parameter int unsigned    TIMEOUT = 0
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [CONFIG.A-1:0]   cmd_addr,
  input  logic [8*CONFIG.N-1:0] cmd_wdata,
  input  logic [CONFIG.N-1:0]   cmd_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [8*CONFIG.N-1:0] rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic                  rsp_timeout,
  axi4_lite_if.master           axi4_m
);

  localparam int unsigned AW = CONFIG.A;
  localparam int unsigned NB = CONFIG.N;
  localparam int unsigned DW = 8 * CONFIG.N;

  // Counter is one bit when the timeout is disabled; it is never consulted then.
  localparam int unsigned TW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TSAT = TW'(TIMEOUT);
  localparam logic [TW-1:0] TLIM = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StWaitB,
    StRead,
    StWaitR,
    StResp
  } state_e;

  state_e          state_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic [NB-1:0]   wstrb_q;
  logic            aw_done_q;
  logic            w_done_q;
  logic            awvalid_q;
  logic            wvalid_q;
  logic            arvalid_q;
  logic            bready_q;
  logic            rready_q;
  logic            cmd_ready_q;
  logic            rsp_valid_q;
  logic [DW-1:0]   rsp_rdata_q;
  logic [1:0]      rsp_resp_q;
  logic            rsp_timeout_q;
  logic [TW-1:0]   tcnt_q;

  logic aw_hs, w_hs, ar_hs, b_hs, r_hs;
  logic busy, advance, tmo_fire;

  // Handshakes, the per-state completing event, and the timeout decision.
  always_comb begin
    aw_hs   = awvalid_q & axi4_m.awready;
    w_hs    = wvalid_q & axi4_m.wready;
    ar_hs   = arvalid_q & axi4_m.arready;
    b_hs    = bready_q & axi4_m.bvalid;
    r_hs    = rready_q & axi4_m.rvalid;
    busy    = 1'b0;
    advance = 1'b0;
    unique case (state_q)
      StWrite: begin
        busy    = 1'b1;
        advance = (aw_done_q | aw_hs) & (w_done_q | w_hs);
      end
      StWaitB: begin
        busy    = 1'b1;
        advance = b_hs;
      end
      StRead: begin
        busy    = 1'b1;
        advance = ar_hs;
      end
      StWaitR: begin
        busy    = 1'b1;
        advance = r_hs;
      end
      default: ;
    endcase
    // A handshake landing in the expiry cycle beats the timeout.
    tmo_fire = (TIMEOUT != 0) && busy && (tcnt_q >= TLIM) && !advance;
  end

  // Transaction FSM with all channel and response outputs registered.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q       <= StIdle;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      aw_done_q     <= 1'b0;
      w_done_q      <= 1'b0;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      bready_q      <= 1'b0;
      rready_q      <= 1'b0;
      cmd_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_resp_q    <= 2'b00;
      rsp_timeout_q <= 1'b0;
      tcnt_q        <= '0;
    end else begin
      if (busy && tcnt_q != TSAT) tcnt_q <= tcnt_q + 1'b1;

      unique case (state_q)
        StIdle: begin
          if (cmd_valid && cmd_ready_q) begin
            addr_q      <= cmd_addr;
            wdata_q     <= cmd_wdata;
            wstrb_q     <= cmd_wstrb;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            tcnt_q      <= '0;
            cmd_ready_q <= 1'b0;
            // Any post-timeout drain ends once a new command is taken.
            bready_q    <= 1'b0;
            rready_q    <= 1'b0;
            if (cmd_write) begin
              state_q   <= StWrite;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
            end else begin
              state_q   <= StRead;
              arvalid_q <= 1'b1;
            end
          end
        end
        StWrite: begin
          if (aw_hs) begin
            aw_done_q <= 1'b1;
            awvalid_q <= 1'b0;
          end
          if (w_hs) begin
            w_done_q <= 1'b1;
            wvalid_q <= 1'b0;
          end
          if (advance) begin
            state_q  <= StWaitB;
            bready_q <= 1'b1;
          end
        end
        StWaitB: begin
          if (b_hs) begin
            state_q       <= StResp;
            bready_q      <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= axi4_m.bresp;
            rsp_timeout_q <= 1'b0;
          end
        end
        StRead: begin
          if (ar_hs) begin
            state_q   <= StWaitR;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
          end
        end
        StWaitR: begin
          if (r_hs) begin
            state_q       <= StResp;
            rready_q      <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_rdata_q   <= axi4_m.rdata;
            rsp_resp_q    <= axi4_m.rresp;
            rsp_timeout_q <= 1'b0;
          end
        end
        StResp: begin
          if (rsp_ready) begin
            state_q     <= StIdle;
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase

      // Abandon the transaction: drop pending valids and drain late B/R beats.
      if (tmo_fire) begin
        state_q       <= StResp;
        awvalid_q     <= 1'b0;
        wvalid_q      <= 1'b0;
        arvalid_q     <= 1'b0;
        bready_q      <= 1'b1;
        rready_q      <= 1'b1;
        rsp_valid_q   <= 1'b1;
        rsp_rdata_q   <= '0;
        rsp_resp_q    <= 2'b11;
        rsp_timeout_q <= 1'b1;
      end
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_resp    = rsp_resp_q;
  assign rsp_timeout = rsp_timeout_q;

  assign axi4_m.awvalid = awvalid_q;
  assign axi4_m.awaddr  = addr_q;
  assign axi4_m.awprot  = 3'b000;
  assign axi4_m.awid    = '0;
  assign axi4_m.wvalid  = wvalid_q;
  assign axi4_m.wdata   = wdata_q;
  assign axi4_m.wstrb   = wstrb_q;
  assign axi4_m.bready  = bready_q;
  assign axi4_m.arvalid = arvalid_q;
  assign axi4_m.araddr  = addr_q;
  assign axi4_m.arprot  = 3'b000;
  assign axi4_m.arid    = '0;
  assign axi4_m.rready  = rready_q;

  // Response IDs are deliberately ignored.
  logic unused_ids;
  assign unused_ids = ^{axi4_m.bid, axi4_m.rid};

endmodule

// File: tb/tb_axi4_lite_cmd_master.sv
// Directed bench for axi4_lite_cmd_master against a small configurable slave.

module tb_axi4_lite_cmd_master;
  import axi4_lite_pkg::*;

  localparam axi4_lite_cfg_t CFG = '{A: 32, N: 4, I: 2};
  localparam int unsigned    TMO = 8;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        rsp_timeout;

  int vectors = 0;
  int miscompares = 0;

  always #5 aclk = ~aclk;

  axi4_lite_if #(.CONFIG(CFG)) bus ();

  axi4_lite_cmd_master #(.CONFIG(CFG), .TIMEOUT(TMO)) dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .cmd_wstrb   (cmd_wstrb),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_resp    (rsp_resp),
    .rsp_timeout (rsp_timeout),
    .axi4_m      (bus)
  );

  // Slave knobs, driven by the test tasks.
  int          aw_delay = 0;
  int          w_delay = 0;
  bit          ar_never = 1'b0;
  bit          b_hold = 1'b0;
  bit          inject_r = 1'b0;
  bit          clr_mon = 1'b0;
  logic [1:0]  b_resp_cfg = 2'b00;
  logic [1:0]  r_resp_cfg = 2'b00;
  logic [31:0] r_data_cfg = '0;

  int          aw_cnt, w_cnt;
  logic        got_aw, got_w, bvalid_s, rvalid_s;
  logic [1:0]  bresp_s, rresp_s;
  logic [31:0] rdata_s;
  logic        aw_hs, w_hs, ar_hs;

  assign bus.awready = bus.awvalid && (aw_cnt >= aw_delay);
  assign bus.wready  = bus.wvalid && (w_cnt >= w_delay);
  assign bus.arready = bus.arvalid && !ar_never;
  assign bus.bvalid  = bvalid_s;
  assign bus.bresp   = bresp_s;
  assign bus.bid     = '0;
  assign bus.rvalid  = rvalid_s;
  assign bus.rdata   = rdata_s;
  assign bus.rresp   = rresp_s;
  assign bus.rid     = '0;
  assign aw_hs = bus.awvalid && bus.awready;
  assign w_hs  = bus.wvalid && bus.wready;
  assign ar_hs = bus.arvalid && bus.arready;

  // Slave: programmable ready delays, B one cycle after AW+W, R one cycle after AR.
  always @(posedge aclk) begin
    if (!aresetn) begin
      aw_cnt <= 0; w_cnt <= 0; got_aw <= 1'b0; got_w <= 1'b0;
      bvalid_s <= 1'b0; rvalid_s <= 1'b0; bresp_s <= 2'b00; rresp_s <= 2'b00; rdata_s <= '0;
    end else begin
      aw_cnt <= (bus.awvalid && !bus.awready) ? aw_cnt + 1 : 0;
      w_cnt  <= (bus.wvalid && !bus.wready) ? w_cnt + 1 : 0;
      if (bvalid_s && bus.bready) bvalid_s <= 1'b0;
      if ((got_aw || aw_hs) && (got_w || w_hs) && !b_hold) begin
        bvalid_s <= 1'b1; bresp_s <= b_resp_cfg; got_aw <= 1'b0; got_w <= 1'b0;
      end else begin
        if (aw_hs) got_aw <= 1'b1;
        if (w_hs) got_w <= 1'b1;
      end
      if (rvalid_s && bus.rready) rvalid_s <= 1'b0;
      if (ar_hs || inject_r) begin
        rvalid_s <= 1'b1; rdata_s <= r_data_cfg; rresp_s <= r_resp_cfg;
      end
    end
  end

  // Monitor: beat counts, WAIT_B entries, payload stability while stalled.
  int          aw_beats, w_beats, b_beats, wait_b_entries;
  logic        bready_p, aw_hold, w_hold, aw_unstable, w_unstable;
  logic [31:0] aw_prev;
  logic [35:0] w_prev;
  always @(posedge aclk) begin
    if (clr_mon) begin
      aw_beats <= 0; w_beats <= 0; b_beats <= 0; wait_b_entries <= 0;
      bready_p <= bus.bready; aw_hold <= 1'b0; w_hold <= 1'b0;
      aw_unstable <= 1'b0; w_unstable <= 1'b0;
    end else begin
      if (aw_hs) aw_beats <= aw_beats + 1;
      if (w_hs) w_beats <= w_beats + 1;
      if (bus.bvalid && bus.bready) b_beats <= b_beats + 1;
      bready_p <= bus.bready;
      if (bus.bready && !bready_p) wait_b_entries <= wait_b_entries + 1;
      aw_hold <= bus.awvalid && !bus.awready;
      aw_prev <= bus.awaddr;
      w_hold  <= bus.wvalid && !bus.wready;
      w_prev  <= {bus.wstrb, bus.wdata};
      if (aw_hold && bus.awvalid && bus.awaddr != aw_prev) aw_unstable <= 1'b1;
      if (w_hold && bus.wvalid && {bus.wstrb, bus.wdata} != w_prev) w_unstable <= 1'b1;
    end
  end

  task automatic clear_mon();
    clr_mon = 1'b1;
    @(negedge aclk);
    clr_mon = 1'b0;
  endtask

  // Called at a negedge in IDLE; returns at the negedge of cycle 1 after acceptance.
  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    @(negedge aclk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output bit got);
    got = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (rsp_valid) begin
        got = 1'b1;
        break;
      end
      @(negedge aclk);
    end
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    @(negedge aclk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    repeat (3) @(negedge aclk);
    vectors++;
    if ({cmd_ready, rsp_valid} !== 2'b10) begin
      miscompares++;
      $display("FAIL reset_handshake: got cmd_ready,rsp_valid=%b want 10", {cmd_ready, rsp_valid});
    end
    vectors++;
    if ({bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_axi: got aw,w,ar,b,r=%b want 00000",
               {bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready});
    end
    vectors++;
    if ({rsp_rdata, rsp_resp, rsp_timeout} !== 35'h0) begin
      miscompares++;
      $display("FAIL reset_rsp: got %h/%b/%b want 0/00/0", rsp_rdata, rsp_resp, rsp_timeout);
    end
    aresetn = 1'b1;
    @(negedge aclk);
  endtask

  task automatic test_read_latency();
    r_data_cfg = 32'hbaadc0de; r_resp_cfg = 2'b00;
    issue(1'b0, 32'h10, 32'h0, 4'h0);
    vectors++;
    if ({bus.arvalid, bus.araddr, bus.arprot, bus.arid} !== {1'b1, 32'h10, 3'b000, 2'b00}) begin
      miscompares++;
      $display("FAIL read_ar_c1: got v=%b a=%h p=%b id=%b want 1/10/000/00",
               bus.arvalid, bus.araddr, bus.arprot, bus.arid);
    end
    @(negedge aclk);
    vectors++;
    if ({rsp_valid, bus.rready} !== 2'b01) begin
      miscompares++;
      $display("FAIL read_c2: got rsp_valid,rready=%b want 01", {rsp_valid, bus.rready});
    end
    @(negedge aclk);
    vectors++;
    if ({rsp_valid, rsp_rdata, rsp_resp, rsp_timeout} !== {1'b1, 32'hbaadc0de, 2'b00, 1'b0}) begin
      miscompares++;
      $display("FAIL read_rsp_c3: got v=%b d=%h r=%b t=%b want 1/baadc0de/00/0",
               rsp_valid, rsp_rdata, rsp_resp, rsp_timeout);
    end
  endtask

  // Continues from the unconsumed read response left by test_read_latency.
  task automatic test_resp_hold();
    bit got;
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if ({rsp_valid, rsp_rdata, cmd_ready} !== {1'b1, 32'hbaadc0de, 1'b0}) begin
        miscompares++;
        $display("FAIL resp_hold[%0d]: got v=%b d=%h cmd_ready=%b want 1/baadc0de/0",
                 i, rsp_valid, rsp_rdata, cmd_ready);
      end
      @(negedge aclk);
    end
    rsp_ready = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h20;
    @(negedge aclk);
    rsp_ready = 1'b0;
    vectors++;
    if ({cmd_ready, rsp_valid} !== 2'b10) begin
      miscompares++;
      $display("FAIL resp_release: got cmd_ready,rsp_valid=%b want 10", {cmd_ready, rsp_valid});
    end
    @(negedge aclk);
    cmd_valid = 1'b0;
    vectors++;
    if ({bus.arvalid, bus.araddr} !== {1'b1, 32'h20}) begin
      miscompares++;
      $display("FAIL resp_next_cmd: got arvalid=%b araddr=%h want 1/20", bus.arvalid, bus.araddr);
    end
    wait_rsp(got);
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL resp_next_rsp: got no response want rsp_valid");
    end
    consume();
  endtask

  task automatic test_write_aw_delay();
    bit got;
    aw_delay = 3; w_delay = 0; b_resp_cfg = 2'b00;
    clear_mon();
    issue(1'b1, 32'h24, 32'h12345678, 4'hf);
    vectors++;
    if ({bus.awvalid, bus.wvalid, bus.wdata, bus.wstrb} !== {2'b11, 32'h12345678, 4'hf}) begin
      miscompares++;
      $display("FAIL wr_aw_c1: got aw=%b w=%b d=%h s=%h want 1/1/12345678/f",
               bus.awvalid, bus.wvalid, bus.wdata, bus.wstrb);
    end
    for (int c = 2; c <= 4; c++) begin
      @(negedge aclk);
      vectors++;
      if ({bus.awvalid, bus.wvalid, bus.awaddr} !== {2'b10, 32'h24}) begin
        miscompares++;
        $display("FAIL wr_aw_hold_c%0d: got aw=%b w=%b addr=%h want 1/0/24",
                 c, bus.awvalid, bus.wvalid, bus.awaddr);
      end
    end
    wait_rsp(got);
    vectors++;
    if ({got, rsp_resp, rsp_rdata, rsp_timeout} !== {1'b1, 2'b00, 32'h0, 1'b0}) begin
      miscompares++;
      $display("FAIL wr_aw_rsp: got v=%b r=%b d=%h t=%b want 1/00/0/0",
               got, rsp_resp, rsp_rdata, rsp_timeout);
    end
    vectors++;
    if ({aw_beats, w_beats, b_beats} !== {32'd1, 32'd1, 32'd1} || aw_unstable !== 1'b0) begin
      miscompares++;
      $display("FAIL wr_aw_beats: got aw=%0d w=%0d b=%0d unstable=%b want 1/1/1/0",
               aw_beats, w_beats, b_beats, aw_unstable);
    end
    consume();
  endtask

  task automatic test_write_w_delay();
    bit got;
    aw_delay = 0; w_delay = 3; b_resp_cfg = 2'b10;
    clear_mon();
    issue(1'b1, 32'h28, 32'hcafef00d, 4'h5);
    wait_rsp(got);
    vectors++;
    if ({got, rsp_resp} !== 3'b110) begin
      miscompares++;
      $display("FAIL wr_w_rsp: got v=%b r=%b want 1/10", got, rsp_resp);
    end
    vectors++;
    if ({aw_beats, w_beats, wait_b_entries} !== {32'd1, 32'd1, 32'd1} || w_unstable !== 1'b0) begin
      miscompares++;
      $display("FAIL wr_w_beats: got aw=%0d w=%0d waitb=%0d unstable=%b want 1/1/1/0",
               aw_beats, w_beats, wait_b_entries, w_unstable);
    end
    consume();
  endtask

  task automatic test_write_same_cycle();
    bit got;
    aw_delay = 2; w_delay = 2; b_resp_cfg = 2'b01;
    clear_mon();
    issue(1'b1, 32'h2c, 32'h0badf00d, 4'h3);
    wait_rsp(got);
    vectors++;
    if ({got, rsp_resp} !== 3'b101) begin
      miscompares++;
      $display("FAIL wr_same_rsp: got v=%b r=%b want 1/01", got, rsp_resp);
    end
    vectors++;
    if ({aw_beats, w_beats, wait_b_entries, b_beats} !== {32'd1, 32'd1, 32'd1, 32'd1}) begin
      miscompares++;
      $display("FAIL wr_same_beats: got aw=%0d w=%0d waitb=%0d b=%0d want 1/1/1/1",
               aw_beats, w_beats, wait_b_entries, b_beats);
    end
    consume();
    aw_delay = 0; w_delay = 0; b_resp_cfg = 2'b00;
  endtask

  task automatic test_timeout();
    ar_never = 1'b1; r_data_cfg = 32'hdeadbeef;
    issue(1'b0, 32'h40, 32'h0, 4'h0);
    repeat (7) @(negedge aclk);
    vectors++;
    if (rsp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL tmo_c8: got rsp_valid=%b want 0", rsp_valid);
    end
    @(negedge aclk);
    vectors++;
    if ({rsp_valid, rsp_resp, rsp_timeout, rsp_rdata} !== {1'b1, 2'b11, 1'b1, 32'h0}) begin
      miscompares++;
      $display("FAIL tmo_c9: got v=%b r=%b t=%b d=%h want 1/11/1/0",
               rsp_valid, rsp_resp, rsp_timeout, rsp_rdata);
    end
    vectors++;
    if ({bus.arvalid, bus.rready, bus.bready} !== 3'b011) begin
      miscompares++;
      $display("FAIL tmo_drain_c9: got arvalid,rready,bready=%b want 011",
               {bus.arvalid, bus.rready, bus.bready});
    end
    ar_never = 1'b0;
    consume();
    inject_r = 1'b1;
    @(negedge aclk);
    inject_r = 1'b0;
    vectors++;
    if ({bus.rvalid, bus.rready} !== 2'b11) begin
      miscompares++;
      $display("FAIL tmo_late_r: got rvalid,rready=%b want 11", {bus.rvalid, bus.rready});
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      vectors++;
      if ({bus.rvalid, rsp_valid} !== 2'b00) begin
        miscompares++;
        $display("FAIL tmo_drained[%0d]: got rvalid,rsp_valid=%b want 00", i, {bus.rvalid, rsp_valid});
      end
    end
  endtask

  task automatic test_reset_mid();
    b_hold = 1'b1;
    issue(1'b1, 32'h30, 32'h11112222, 4'hf);
    @(negedge aclk);
    vectors++;
    if (bus.bready !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_mid_waitb: got bready=%b want 1", bus.bready);
    end
    aresetn = 1'b0;
    @(negedge aclk);
    vectors++;
    if ({bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready, cmd_ready, rsp_valid}
        !== 7'b0000010) begin
      miscompares++;
      $display("FAIL rst_mid: got aw,w,ar,b,r,cmd_ready,rsp_valid=%b want 0000010",
               {bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready, cmd_ready, rsp_valid});
    end
    aresetn = 1'b1;
    b_hold = 1'b0;
    @(negedge aclk);
  endtask

  task automatic test_back_to_back();
    int accepts = 0;
    int last = -1;
    int bad_gap = 0;
    rsp_ready = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h50;
    for (int i = 0; i < 16; i++) begin
      if (cmd_ready) begin
        if (last >= 0 && i - last != 4) bad_gap++;
        last = i;
        accepts++;
      end
      @(negedge aclk);
    end
    cmd_valid = 1'b0;
    vectors++;
    if (accepts != 4 || bad_gap != 0) begin
      miscompares++;
      $display("FAIL b2b_rate: got %0d accepts, %0d bad gaps want 4 accepts, 0 bad gaps",
               accepts, bad_gap);
    end
    repeat (6) @(negedge aclk);
    rsp_ready = 1'b0;
    vectors++;
    if ({cmd_ready, rsp_valid} !== 2'b10) begin
      miscompares++;
      $display("FAIL b2b_idle: got cmd_ready,rsp_valid=%b want 10", {cmd_ready, rsp_valid});
    end
  endtask

  initial begin
    @(negedge aclk);
    test_reset();
    test_read_latency();
    test_resp_hold();
    test_write_aw_delay();
    test_write_w_delay();
    test_write_same_cycle();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
